lt24_pixel_arbiter: RTL and testbench

- Shares the single LT24 display driver pixel-write port between NUM_REQ independent renderers, for example the waveform trace, the grid overlay and the text/cursor overlay.
- Sits between the renderers and the LT24 driver, inside lcd_scope.
- Selects renderers round-robin, with an optional burst lock so a renderer can finish a line uninterrupted.
- Blocks all traffic until display initialisation is complete, and discards pixels whose coordinates fall outside the panel.

---
 rtl/lt24_pkg.sv | 21 ++
 rtl/rr_priority_select.sv | 36 +++
 rtl/lt24_pixel_arbiter.sv | 105 ++++++++++
 tb/tb_lt24_pixel_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared LT24 panel constants and pixel types used by the pixel-port arbiter.
package lt24_pkg;
  localparam int LT24_WIDTH  = 240;
  localparam int LT24_HEIGHT = 320;
  localparam int LT24_XW     = 8;
  localparam int LT24_YW     = 9;
  localparam int GID_W       = 2;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [LT24_XW-1:0] x;
    logic [LT24_YW-1:0] y;
    rgb565_t            data;
  } pix_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick with an optional forced (locked) winner.
module rr_priority_select #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  input  logic               i_lock_en,
  input  logic [PW-1:0]      i_lock_idx,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);
  logic [NUM_REQ-1:0] w_rot;
  logic [PW:0]        w_idx;

  always_comb begin
    // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
    w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
    w_idx   = '0;
    o_valid = 1'b0;
    o_grant = '0;
    if (i_lock_en) begin
      w_idx   = {1'b0, i_lock_idx};
      o_valid = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_idx   = (PW+1)'(i_ptr) + (PW+1)'(k);
          o_valid = 1'b1;
        end
      end
      if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ);
    end
    if (o_valid) o_grant = NUM_REQ'(1) << w_idx;
  end
endmodule

// File: rtl/lt24_pixel_arbiter.sv
// Round-robin arbiter sharing the LT24 pixel-write port between renderers,
// with burst lock, display-ready gating and out-of-panel pixel discard.
module lt24_pixel_arbiter
  import lt24_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = LT24_WIDTH,
  parameter int HEIGHT  = LT24_HEIGHT,
  parameter int XW      = LT24_XW,
  parameter int YW      = LT24_YW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  displayReady,
  input  logic [NUM_REQ-1:0]    reqValid,
  input  logic [NUM_REQ-1:0]    reqLock,
  input  logic [NUM_REQ*XW-1:0] reqX,
  input  logic [NUM_REQ*YW-1:0] reqY,
  input  logic [NUM_REQ*16-1:0] reqData,
  output logic [NUM_REQ-1:0]    reqReady,
  output logic [XW-1:0]         xAddr,
  output logic [YW-1:0]         yAddr,
  output logic [15:0]           pixelData,
  output logic                  pixelWrite,
  input  logic                  pixelReady,
  output logic [1:0]            grantId,
  output logic [15:0]           dropCount
);
  arb_state_t         r_state, w_state_nxt;
  logic [GID_W-1:0]   r_ptr, r_lock_idx, r_gid, w_win, w_ptr_nxt;
  logic               r_lock, w_lock_en, w_sel_valid, w_xfer, w_accept, w_oor;
  logic [NUM_REQ-1:0] w_grant;
  pix_req_t           w_pix, r_pix;
  logic [15:0]        r_drop;

  assign w_lock_en = r_lock & reqValid[r_lock_idx];

  rr_priority_select #(.NUM_REQ(NUM_REQ), .PW(GID_W)) u_sel (
    .i_req      (reqValid),
    .i_ptr      (r_ptr),
    .i_lock_en  (w_lock_en),
    .i_lock_idx (r_lock_idx),
    .o_grant    (w_grant),
    .o_valid    (w_sel_valid)
  );

  always_comb begin
    w_win = '0;
    w_pix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win = GID_W'(i);
        w_pix = {reqX[i*XW +: XW], reqY[i*YW +: YW], reqData[i*16 +: 16]};
      end
    end
  end

  assign w_oor     = (int'(w_pix.x) >= WIDTH) || (int'(w_pix.y) >= HEIGHT);
  assign w_xfer    = (r_state == ST_FULL) && pixelReady;
  // reset_n gates the ack so reqReady is low for the whole reset interval.
  assign w_accept  = reset_n && displayReady && w_sel_valid &&
                     ((r_state == ST_IDLE) || w_xfer);
  assign reqReady  = w_accept ? w_grant : '0;
  assign w_ptr_nxt = (w_win == GID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_oor) w_state_nxt = ST_FULL;
      ST_FULL: if (w_xfer) w_state_nxt = (w_accept && !w_oor) ? ST_FULL : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_gid      <= '0;
      r_pix      <= '0;
      r_drop     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!displayReady)                       r_lock <= 1'b0;
      else if (w_accept)                       r_lock <= |(reqLock & w_grant);
      else if (r_lock && !reqValid[r_lock_idx]) r_lock <= 1'b0;
      if (w_accept) begin
        r_lock_idx <= w_win;
        r_ptr      <= w_ptr_nxt;
        r_gid      <= w_win;
        if (!w_oor)                  r_pix  <= w_pix;
        else if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign pixelWrite = (r_state == ST_FULL);
  assign xAddr      = r_pix.x;
  assign yAddr      = r_pix.y;
  assign pixelData  = r_pix.data;
  assign grantId    = r_gid;
  assign dropCount  = r_drop;
endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Bench for lt24_pixel_arbiter: directed table, corner sequences, random vs model.
module tb_lt24_pixel_arbiter;
  localparam int N = 3, XW = 8, YW = 9;

  logic              clock = 1'b0, reset_n = 1'b0, displayReady = 1'b0, pixelReady = 1'b0;
  logic [N-1:0]      reqValid = '0, reqLock = '0, reqReady;
  logic [N*XW-1:0]   reqX = '0;
  logic [N*YW-1:0]   reqY = '0;
  logic [N*16-1:0]   reqData = '0;
  logic [XW-1:0]     xAddr;
  logic [YW-1:0]     yAddr;
  logic [15:0]       pixelData, dropCount;
  logic              pixelWrite;
  logic [1:0]        grantId;

  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;

  lt24_pixel_arbiter dut (
    .clock(clock), .reset_n(reset_n), .displayReady(displayReady),
    .reqValid(reqValid), .reqLock(reqLock), .reqX(reqX), .reqY(reqY),
    .reqData(reqData), .reqReady(reqReady), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .grantId(grantId), .dropCount(dropCount)
  );

  // Behavioural reference: one-entry output slot, next-search pointer, lock owner.
  bit m_full, m_lock;
  int m_lockid, m_ptr, m_gid, m_drop, m_x, m_y, m_d;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    m_full = 0; m_lock = 0; m_lockid = 0; m_ptr = 0;
    m_gid = 0; m_drop = 0; m_x = 0; m_y = 0; m_d = 0;
  endfunction

  function automatic int get_x(input int i); return int'(reqX[i*XW +: XW]); endfunction
  function automatic int get_y(input int i); return int'(reqY[i*YW +: YW]); endfunction
  function automatic int get_d(input int i); return int'(reqData[i*16 +: 16]); endfunction

  function automatic void set_req(input int i, input int x, input int y, input int d);
    reqX[i*XW +: XW] = XW'(x);
    reqY[i*YW +: YW] = YW'(y);
    reqData[i*16 +: 16] = 16'(d);
  endfunction

  function automatic int model_winner();
    if (!reset_n || !displayReady || reqValid == '0) return -1;
    if (m_full && !pixelReady) return -1;
    if (m_lock && reqValid[m_lockid]) return m_lockid;
    for (int k = 0; k < N; k++)
      if (reqValid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Compare DUT against model for this cycle, then advance the model.
  task automatic step_check();
    int w;
    w = model_winner();
    check("reqReady", int'(reqReady), (w < 0) ? 0 : (1 << w));
    check("pixelWrite", int'(pixelWrite), int'(m_full));
    if (m_full) begin
      check("xAddr", int'(xAddr), m_x);
      check("yAddr", int'(yAddr), m_y);
      check("pixelData", int'(pixelData), m_d);
    end
    check("grantId", int'(grantId), m_gid);
    check("dropCount", int'(dropCount), m_drop);
    if (!displayReady)                    m_lock = 0;
    else if (w >= 0) begin                m_lock = reqLock[w]; m_lockid = w; end
    else if (m_lock && !reqValid[m_lockid]) m_lock = 0;
    if (m_full && pixelReady) m_full = 0;
    if (w >= 0) begin
      m_gid = w;
      m_ptr = (w + 1) % N;
      if (get_x(w) >= 240 || get_y(w) >= 320) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
      else begin m_full = 1; m_x = get_x(w); m_y = get_y(w); m_d = get_d(w); end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    step_check();
    @(posedge clock); #1;
  endtask

  typedef struct {
    bit       dr;
    bit [2:0] vld, lck;
    bit       pr;
    bit [2:0] e_rdy;
    bit       e_pw;
    int       e_gid;
  } vec_t;
  vec_t tbl[19];

  int xfers;

  initial begin
    // round-robin 0,1,2,0,1,2 then lock burst on 1, then lock owner dropping valid
    tbl[0]  = '{1, 3'b111, 3'b000, 1, 3'b001, 0, 0};
    tbl[1]  = '{1, 3'b111, 3'b000, 1, 3'b010, 1, 0};
    tbl[2]  = '{1, 3'b111, 3'b000, 1, 3'b100, 1, 1};
    tbl[3]  = '{1, 3'b111, 3'b000, 1, 3'b001, 1, 2};
    tbl[4]  = '{1, 3'b111, 3'b000, 1, 3'b010, 1, 0};
    tbl[5]  = '{1, 3'b111, 3'b000, 1, 3'b100, 1, 1};
    tbl[6]  = '{1, 3'b111, 3'b010, 1, 3'b001, 1, 2};
    tbl[7]  = '{1, 3'b111, 3'b010, 1, 3'b010, 1, 0};
    tbl[8]  = '{1, 3'b111, 3'b010, 1, 3'b010, 1, 1};
    tbl[9]  = '{1, 3'b111, 3'b010, 1, 3'b010, 1, 1};
    tbl[10] = '{1, 3'b111, 3'b010, 1, 3'b010, 1, 1};
    tbl[11] = '{1, 3'b111, 3'b000, 1, 3'b010, 1, 1};
    tbl[12] = '{1, 3'b111, 3'b000, 1, 3'b100, 1, 1};
    tbl[13] = '{1, 3'b000, 3'b000, 1, 3'b000, 1, 2};
    tbl[14] = '{1, 3'b000, 3'b000, 1, 3'b000, 0, 2};
    tbl[15] = '{1, 3'b111, 3'b001, 1, 3'b001, 0, 2};
    tbl[16] = '{1, 3'b110, 3'b000, 1, 3'b010, 1, 0};
    tbl[17] = '{1, 3'b000, 3'b000, 1, 3'b000, 1, 1};
    tbl[18] = '{1, 3'b000, 3'b000, 1, 3'b000, 0, 1};

    for (int i = 0; i < N; i++) set_req(i, 5 + 10*i, 7 + 20*i, 16'h1000*(i+1) + i);
    model_reset();

    // Reset state, with requests and displayReady up to prove the ack is gated.
    reqValid = '1; displayReady = 1'b1;
    #12;
    check("rst_reqReady", int'(reqReady), 0);
    check("rst_pixelWrite", int'(pixelWrite), 0);
    check("rst_xAddr", int'(xAddr), 0);
    check("rst_grantId", int'(grantId), 0);
    check("rst_dropCount", int'(dropCount), 0);
    displayReady = 1'b0;
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // Gating: display not ready for 20 cycles.
    pixelReady = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check("gate_rdy", int'(reqReady), 0);
      step_check();
      @(posedge clock); #1;
    end

    for (int i = 0; i < 19; i++) begin
      displayReady = tbl[i].dr; reqValid = tbl[i].vld;
      reqLock = tbl[i].lck; pixelReady = tbl[i].pr;
      @(negedge clock);
      check($sformatf("tbl%0d_rdy", i), int'(reqReady), int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_pw", i), int'(pixelWrite), int'(tbl[i].e_pw));
      check($sformatf("tbl%0d_gid", i), int'(grantId), tbl[i].e_gid);
      step_check();
      @(posedge clock); #1;
    end

    // Backpressure: held pixel stays put while the source moves on.
    set_req(0, 10, 20, 16'hF800);
    reqValid = 3'b001; reqLock = '0; pixelReady = 1'b0;
    @(negedge clock);
    check("bp_accept", int'(reqReady), 1);
    step_check();
    @(posedge clock); #1;
    set_req(0, 99, 99, 16'h1234);
    xfers = 0;
    repeat (7) begin
      @(negedge clock);
      check("bp_x", int'(xAddr), 10);
      check("bp_y", int'(yAddr), 20);
      check("bp_data", int'(pixelData), 16'hF800);
      check("bp_rdy", int'(reqReady), 0);
      if (pixelWrite && pixelReady) xfers++;
      step_check();
      @(posedge clock); #1;
    end
    pixelReady = 1'b1; reqValid = '0;
    repeat (2) begin
      @(negedge clock);
      if (pixelWrite && pixelReady) xfers++;
      step_check();
      @(posedge clock); #1;
    end
    check("bp_xfers", xfers, 1);

    // Range check on requester 2.
    reqValid = 3'b100;
    set_req(2, 240, 5, 16'h00AA);
    @(negedge clock); check("oor1_rdy", int'(reqReady), 4); step_check(); @(posedge clock); #1;
    set_req(2, 0, 320, 16'h00BB);
    @(negedge clock);
    check("oor2_rdy", int'(reqReady), 4);
    check("oor2_pw", int'(pixelWrite), 0);
    step_check(); @(posedge clock); #1;
    set_req(2, 239, 319, 16'h07E0);
    @(negedge clock);
    check("edge_rdy", int'(reqReady), 4);
    check("edge_pw", int'(pixelWrite), 0);
    step_check(); @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    check("edge_pw1", int'(pixelWrite), 1);
    check("edge_x", int'(xAddr), 239);
    check("edge_y", int'(yAddr), 319);
    check("drop2", int'(dropCount), 2);
    step_check(); @(posedge clock); #1;
    cyc();

    // Reset while FULL with the lock held by requester 0.
    pixelReady = 1'b0; reqValid = 3'b001; reqLock = 3'b001;
    cyc();
    #3 reset_n = 1'b0;
    #1;
    check("mrst_pw", int'(pixelWrite), 0);
    check("mrst_rdy", int'(reqReady), 0);
    model_reset();
    reqValid = '0; reqLock = '0; pixelReady = 1'b1;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    reqValid = 3'b111;
    @(negedge clock); check("post_rst_rdy0", int'(reqReady), 1); step_check(); @(posedge clock); #1;
    @(negedge clock); check("post_rst_rdy1", int'(reqReady), 2); step_check(); @(posedge clock); #1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      displayReady = ($urandom % 8) != 0;
      pixelReady   = ($urandom % 4) != 0;
      reqValid     = N'($urandom);
      for (int i = 0; i < N; i++) begin
        reqLock[i] = ($urandom % 10) < 3;
        set_req(i, $urandom_range(0, 255), $urandom_range(0, 340), $urandom);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
